// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver assembling four bytes into a 32-bit word
module uart_receiver #(
    parameter int CLKS_PER_BIT = 16,
    parameter int WORD_BYTES   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RxD,
    input  logic        clr_word,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic [31:0] data,
    output logic        data_valid,
    output logic        frame_err,
    output logic        rx_busy
);

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  HALF_CNT  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  LAST_CNT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [1:0]     LANE_LAST = 2'(WORD_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_sync;
    logic          r_rxs_prev;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    r_bit;
    logic [2:0]    w_bit_nxt;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nxt;
    logic          w_accept;
    logic          w_ferr;
    logic          w_rxs;
    logic [1:0]    r_lane;
    logic [31:0]   r_partial;
    logic [31:0]   w_word;
    logic [7:0]    r_byte;
    logic          r_byte_valid;
    logic [31:0]   r_data;
    logic          r_data_valid;
    logic          r_frame_err;

    assign w_rxs = r_sync[1];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_accept    = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (r_rxs_prev && !w_rxs) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (r_cnt == HALF_CNT) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = w_rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == LAST_CNT) begin
                    w_cnt_nxt          = '0;
                    w_shift_nxt[r_bit] = w_rxs;
                    w_bit_nxt          = r_bit + 1'b1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (r_cnt == LAST_CNT) begin
                    w_cnt_nxt = '0;
                    if (w_rxs) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                w_cnt_nxt = '0;
                if (w_rxs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_word = r_partial;
        w_word[{r_lane, 3'b000} +: 8] = r_shift;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync       <= 2'b11;
            r_rxs_prev   <= 1'b1;
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_lane       <= '0;
            r_partial    <= '0;
            r_byte       <= '0;
            r_byte_valid <= 1'b0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_sync       <= {r_sync[0], RxD};
            r_rxs_prev   <= w_rxs;
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_bit        <= w_bit_nxt;
            r_shift      <= w_shift_nxt;
            r_byte_valid <= w_accept;
            r_frame_err  <= w_ferr;
            r_data_valid <= 1'b0;
            if (w_accept) begin
                r_byte <= r_shift;
            end
            // A clear in the same cycle as an accept drops that byte from the word.
            if (clr_word) begin
                r_lane    <= '0;
                r_partial <= '0;
            end else if (w_accept) begin
                if (r_lane == LANE_LAST) begin
                    r_data       <= w_word;
                    r_data_valid <= 1'b1;
                    r_lane       <= '0;
                    r_partial    <= '0;
                end else begin
                    r_partial <= w_word;
                    r_lane    <= r_lane + 1'b1;
                end
            end
        end
    end

    assign byte_out   = r_byte;
    assign byte_valid = r_byte_valid;
    assign data       = r_data;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;
    assign rx_busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver
module tb_uart_receiver;

    localparam int CPB = 16;
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        RxD;
    logic        clr_word;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic [31:0] data;
    logic        data_valid;
    logic        frame_err;
    logic        rx_busy;

    uart_receiver #(.CLKS_PER_BIT(CPB), .WORD_BYTES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .RxD        (RxD),
        .clr_word   (clr_word),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         t;
        logic       err;
        logic [7:0] b;
    } ev_t;

    ev_t         evq[$];
    ev_t         ev;
    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    logic        m_clr_edge = 1'b0;
    logic        m_rst_edge = 1'b0;
    logic [7:0]  m_part[4];
    int          m_k = 0;
    logic [7:0]  m_byte = 8'h00;
    logic [31:0] m_data = 32'h0;
    logic        exp_dv;
    logic        m_prev_bv = 1'b0;
    logic        m_prev_dv = 1'b0;
    logic        m_prev_fe = 1'b0;
    int          busy_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_lat(input string nm, input int act, input int exp);
        n_chk++;
        if (act < exp - 1 || act > exp + 1) begin
            n_fail++;
            $display("FAIL %s: strobe at cycle %0d expected %0d +-1", nm, act, exp);
        end
    endtask

    task automatic bad(input string nm, input int act, input int exp);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Model: each frame's outcome is scheduled from the spec's latency formula.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(posedge clk);
        #1;
        evq.push_back('{cyc + LAT, !stop_bit, b});
        RxD = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1 RxD = b[i];
        end
        repeat (CPB) @(posedge clk);
        #1 RxD = stop_bit;
        repeat (CPB - 1) @(posedge clk);
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 clr_word = 1'b1;
        @(posedge clk);
        #1 clr_word = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        m_clr_edge <= clr_word;
        m_rst_edge <= rst;
    end

    always @(negedge clk) begin
        if (!m_rst_edge) begin
            m_k    = 0;
            m_part = '{default: 8'h00};
            m_byte = 8'h00;
            m_data = 32'h0;
            evq.delete();
            chk("rst_byte_valid", byte_valid, 0);
            chk("rst_data_valid", data_valid, 0);
            chk("rst_frame_err", frame_err, 0);
            chk("rst_rx_busy", rx_busy, 0);
        end else begin
            exp_dv = 1'b0;
            if (byte_valid) begin
                if (evq.size() == 0 || evq[0].err) begin
                    bad("unexpected_byte_valid", 1, 0);
                end else begin
                    ev = evq.pop_front();
                    chk_lat("byte_latency", cyc, ev.t);
                    m_byte = ev.b;
                    if (m_clr_edge) begin
                        m_k    = 0;
                        m_part = '{default: 8'h00};
                    end else begin
                        m_part[m_k] = ev.b;
                        if (m_k == 3) begin
                            m_data = {m_part[3], m_part[2], m_part[1], m_part[0]};
                            exp_dv = 1'b1;
                            m_k    = 0;
                        end else begin
                            m_k++;
                        end
                    end
                end
            end else if (m_clr_edge) begin
                m_k    = 0;
                m_part = '{default: 8'h00};
            end
            if (frame_err) begin
                if (evq.size() == 0 || !evq[0].err) begin
                    bad("unexpected_frame_err", 1, 0);
                end else begin
                    ev = evq.pop_front();
                    chk_lat("frame_err_latency", cyc, ev.t);
                end
            end
            if (evq.size() > 0 && cyc > evq[0].t + 1) begin
                bad("missing_strobe", 0, 1);
                void'(evq.pop_front());
            end
            chk("data_valid", data_valid, exp_dv);
            chk("bv_fe_exclusive", byte_valid & frame_err, 0);
            chk("strobe_repeat", (byte_valid & m_prev_bv) | (data_valid & m_prev_dv)
                                 | (frame_err & m_prev_fe), 0);
        end
        chk("byte_out", byte_out, m_byte);
        chk("data", data, m_data);
        m_prev_bv = byte_valid;
        m_prev_dv = data_valid;
        m_prev_fe = frame_err;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        RxD      = 1'b1;
        rst      = 1'b0;
        clr_word = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("reset_byte_out", byte_out, 8'h00);
        chk("reset_data", data, 32'h0);
        chk("reset_rx_busy", rx_busy, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (20) @(posedge clk);

        send_frame(8'hA5, 1'b1);
        settle();
        chk("t1_byte_out", byte_out, 8'hA5);
        chk("t1_data", data, 32'h0);
        pulse_clr();

        send_frame(8'h78, 1'b1);
        send_frame(8'h56, 1'b1);
        send_frame(8'h34, 1'b1);
        send_frame(8'h12, 1'b1);
        settle();
        chk("t2_data", data, 32'h12345678);
        chk("t2_byte_out", byte_out, 8'h12);

        send_frame(8'h55, 1'b0);
        repeat (40 * CPB) @(posedge clk);
        #1 RxD = 1'b1;
        repeat (CPB) @(posedge clk);
        send_frame(8'h3C, 1'b1);
        settle();
        chk("t3_byte_out", byte_out, 8'h3C);
        chk("t3_data_held", data, 32'h12345678);
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        send_frame(8'h03, 1'b1);
        settle();
        chk("t3_lane_kept", data, 32'h0302013C);

        busy_cnt = 0;
        fork
            begin
                @(posedge clk);
                #1 RxD = 1'b0;
                repeat (5) @(posedge clk);
                #1 RxD = 1'b1;
            end
            begin
                repeat (40) begin
                    @(negedge clk);
                    if (rx_busy) busy_cnt++;
                end
            end
        join
        chk("t4_busy_window", (busy_cnt >= 1 && busy_cnt <= CPB / 2 + 2), 1);
        chk("t4_idle_after", rx_busy, 0);

        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        pulse_clr();
        send_frame(8'hDD, 1'b1);
        send_frame(8'hCC, 1'b1);
        send_frame(8'hBB, 1'b1);
        send_frame(8'hAA, 1'b1);
        settle();
        chk("t5_data", data, 32'hAABBCCDD);
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        send_frame(8'h03, 1'b1);
        fork
            send_frame(8'h04, 1'b1);
            begin
                @(posedge clk);
                repeat (LAT - 1) @(posedge clk);
                #1 clr_word = 1'b1;
                @(posedge clk);
                #1 clr_word = 1'b0;
            end
        join
        settle();
        chk("t5_clr_wins_data", data, 32'hAABBCCDD);
        chk("t5_clr_wins_byte", byte_out, 8'h04);
        send_frame(8'h05, 1'b1);
        send_frame(8'h06, 1'b1);
        send_frame(8'h07, 1'b1);
        send_frame(8'h08, 1'b1);
        settle();
        chk("t5_after_clr", data, 32'h08070605);

        @(posedge clk);
        #1 RxD = 1'b0;
        repeat (3 * CPB + CPB / 2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (CPB + CPB / 2) @(posedge clk);
        #1 RxD = 1'b1;
        @(negedge clk);
        chk("t6_rst_byte_out", byte_out, 8'h00);
        chk("t6_rst_data", data, 32'h0);
        chk("t6_rst_busy", rx_busy, 0);
        repeat (CPB + CPB / 2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (4 * CPB) @(posedge clk);
        send_frame(8'h81, 1'b1);
        settle();
        chk("t6_byte_out", byte_out, 8'h81);
        chk("t6_data", data, 32'h0);

        repeat (50) @(posedge clk);
        chk("events_drained", evq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Receive side of the team's 8N1 UART link. Deserialises bytes from RxD, LSB first.
- Assembles four consecutive bytes, first byte into the least-significant lane, into a 32-bit word for the matrix-multiply datapath.
- Flags framing errors. Pulses one-cycle valid strobes per byte and per word.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit; must be >= 4 and even.
- WORD_BYTES, 4, bytes per assembled word; fixed at 4 for the 32-bit output.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk)
- RxD  input  1  UART serial input, idle high, asynchronous to clk
- clr_word  input  1  discard the partially assembled word; next byte goes to lane 0
- byte_out  output  8  last correctly framed byte
- byte_valid  output  1  one-cycle pulse when byte_out updates
- data  output  32  last completed word
- data_valid  output  1  one-cycle pulse when data updates
- frame_err  output  1  one-cycle pulse when the stop bit samples 0
- rx_busy  output  1  high whenever state != IDLE

Behaviour:
- Input sync: RxD passes through a 2-flop synchroniser. Both flops reset to 1. All decisions use the synchronised signal rxs, which adds 2 cycles of input latency.
- Reset (rst == 0 at posedge clk):
  - state = IDLE; bit counter, sample counter and lane index = 0.
  - byte_out = 0, data = 0, byte_valid = 0, data_valid = 0, frame_err = 0, rx_busy = 0.
  - Reset mid-frame abandons the frame. Reception restarts only on a new falling edge of rxs.
- States:
  - IDLE: a falling edge of rxs (previous 1, current 0) -> START; sample counter cleared.
  - START: wait CLKS_PER_BIT/2 cycles to reach mid-bit, then sample.
    - rxs == 0 -> DATA.
    - rxs == 1 -> IDLE. This is a glitch rejection: no strobe, no error.
  - DATA: sample every CLKS_PER_BIT cycles from the start mid-point. Sample i (0..7) goes into shift bit i, LSB first. After sample 7 -> STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - rxs == 1: byte accepted. In the next cycle byte_out = shift and byte_valid = 1, then -> IDLE.
    - rxs == 0: frame_err = 1 for one cycle. byte_out, lane index and data are unchanged. -> BREAK.
  - BREAK: wait until rxs == 1, then -> IDLE. A held-low line produces exactly one frame_err.
- Word assembly:
  - An accepted byte is written to data lane [8*k+7:8*k], where k is the lane index (0..3). k then increments.
  - When k == 3 on an accepted byte: the same cycle as byte_valid sets data to the full word and data_valid = 1; k wraps to 0.
  - data holds between words. Partially assembled lanes are held in an internal register; data only updates on completion.
- clr_word: sets k = 0 and clears the internal partial word.
  - If clr_word coincides with an accepted byte, the clear wins: byte_valid still pulses, the byte is not stored and data_valid does not pulse.
- Strobes: byte_valid, data_valid and frame_err are never high for more than one consecutive cycle. byte_valid and frame_err are mutually exclusive.
- Latency: from the stop-bit mid-sample to byte_valid is 1 cycle. From the RxD falling edge to byte_valid is 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles, ±1 for edge alignment.
- Back-to-back frames: a start bit immediately after the stop mid-point is detected, because IDLE is re-entered before the stop bit ends.
- Baud tolerance: correct reception with ±3% bit-period mismatch at CLKS_PER_BIT = 16.

Test Plan:
- Reset, then RxD frame 0xA5 (CLKS_PER_BIT = 16) -> byte_valid pulses once, byte_out = 0xA5, frame_err = 0, data_valid = 0, data = 0.
- Four back-to-back frames 0x78, 0x56, 0x34, 0x12 with no idle gap -> four byte_valid pulses; data_valid coincides with the 4th; data = 0x12345678.
- 0x55 frame with stop bit driven 0, line held low 40 bit-times, then frame 0x3C -> exactly one frame_err pulse; lane index not advanced; byte_out = 0x3C after the recovery frame.
- RxD low pulse of 5 cycles (< CLKS_PER_BIT/2) while idle -> returns to IDLE; no byte_valid and no frame_err; rx_busy high for ≤ 8 + 2 cycles.
- Send 0x11 and 0x22, assert clr_word, then send 0xDD, 0xCC, 0xBB, 0xAA -> data = 0xAABBCCDD. Separately, clr_word in the same cycle as a 4th-byte accept -> no data_valid.
- rst = 0 midway through the DATA bits of a frame, released low mid-frame -> all outputs 0; no byte_valid for the truncated frame; the next full frame 0x81 is received correctly.
